// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster path.
// Holds the 640x480@60 timing constants, derived line/frame totals, the 10-bit coordinate
// type, colour constants and the bundle of per-pixel timing terms that is delayed to line
// up with the draw pipeline.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  typedef logic [7:0] rgb_t;
  localparam rgb_t COLOR_BLACK = 8'h00;
  localparam rgb_t COLOR_WHITE = 8'hFF;
  localparam rgb_t COLOR_RED   = 8'hE0;

  // Undelayed timing terms for one pixel position.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic vid;
  } sync_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register for the {hsync, vsync, vid} timing bundle.
// Ports:
//   clk_i  - clock, every edge shifts
//   rst_i  - synchronous active-high reset, loads RstVal into every stage
//   d_i    - undelayed timing terms
//   q_o    - timing terms delayed by Depth clocks (Depth = 0 is a pass-through)
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned Depth  = 2,
  parameter sync_t       RstVal = '0
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  sync_t d_i,
  output sync_t q_o
);

  if (Depth == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk_i;
    // Still honour reset so the outputs read idle while rst is held.
    assign q_o = rst_i ? RstVal : d_i;
  end else begin : g_pipe
    sync_t [Depth-1:0] stage_q;
    sync_t [Depth-1:0] stage_d;

    assign stage_d[0] = d_i;
    for (genvar i = 1; i < Depth; i++) begin : g_stage
      assign stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stage_q <= {Depth{RstVal}};
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Divides clk down to the pixel rate, runs the horizontal/vertical counters that feed the
// draw path, and re-aligns sync/blanking to the draw pipeline latency before gating the
// returned colour onto the DAC pins.
// Ports:
//   clk        - system clock
//   rst        - synchronous reset, active-high
//   color_in   - RRRGGGBB colour from draw, valid PIPE_DLY clks after the coordinates
//   pixel_x/y  - current horizontal/vertical counters
//   pix_en     - one-clk strobe, counters advance on the following edge
//   frame_tick - one-clk pulse in the first cycle the counters read (0,0)
//   hsync/vsync/video_on - timing terms delayed by PIPE_DLY clks
//   rgb_out    - registered colour, black outside the delayed active area
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned PIPE_DLY = 2,
  parameter logic        SYNC_ACT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] color_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pix_en,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [7:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..4");
  end

  // Inclusive bounds so totals of exactly 1024 do not wrap in 10 bits.
  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_LAST = coord_t'(H_ACTIVE - 1);
  localparam coord_t V_VIS_LAST = coord_t'(V_ACTIVE - 1);
  localparam coord_t HS_FIRST   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [1:0] PH_LAST = 2'(CLK_DIV - 1);

  localparam sync_t SYNC_IDLE = '{hsync: ~SYNC_ACT, vsync: ~SYNC_ACT, vid: 1'b0};

  logic [1:0] phase_q, phase_d;
  coord_t     h_q, h_d;
  coord_t     v_q, v_d;
  logic       frame_tick_q, frame_tick_d;
  rgb_t       rgb_q, rgb_d;
  logic       pix_en_c;
  sync_t      raw;
  sync_t      dly;

  always_comb begin
    // Masked by rst so CLK_DIV = 1 still shows no strobe in the reset cycle.
    pix_en_c     = (phase_q == PH_LAST) && !rst;
    phase_d      = (phase_q == PH_LAST) ? 2'd0 : phase_q + 2'd1;
    h_d          = h_q;
    v_d          = v_q;
    frame_tick_d = 1'b0;
    if (pix_en_c) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d          = '0;
          frame_tick_d = 1'b1;
        end else begin
          v_d = v_q + coord_t'(1);
        end
      end else begin
        h_d = h_q + coord_t'(1);
      end
    end
  end

  always_comb begin
    raw = SYNC_IDLE;
    if (h_q >= HS_FIRST && h_q <= HS_LAST) raw.hsync = SYNC_ACT;
    if (v_q >= VS_FIRST && v_q <= VS_LAST) raw.vsync = SYNC_ACT;
    raw.vid = (h_q <= H_VIS_LAST) && (v_q <= V_VIS_LAST);
  end

  vga_sync_delay #(
    .Depth  (PIPE_DLY),
    .RstVal (SYNC_IDLE)
  ) u_sync_delay (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (raw),
    .q_o   (dly)
  );

  always_comb begin
    rgb_d = dly.vid ? color_in : COLOR_BLACK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      h_q          <= '0;
      v_q          <= '0;
      // Counters restart at (0,0), so the first cycle after release is a frame start.
      frame_tick_q <= 1'b1;
      rgb_q        <= COLOR_BLACK;
    end else begin
      phase_q      <= phase_d;
      h_q          <= h_d;
      v_q          <= v_d;
      frame_tick_q <= frame_tick_d;
      rgb_q        <= rgb_d;
    end
  end

  assign pixel_x    = h_q;
  assign pixel_y    = v_q;
  assign pix_en     = pix_en_c;
  // Hide the preloaded tick while rst is still held.
  assign frame_tick = frame_tick_q & ~rst;
  assign hsync      = dly.hsync;
  assign vsync      = dly.vsync;
  assign video_on   = dly.vid;
  assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance (CLK_DIV=2, PIPE_DLY=2),
// a CLK_DIV=1/PIPE_DLY=0 instance, and two shrunken-timing instances (16x8 totals) so that
// whole frames fit in a short run.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] color;

  always #5 clk = ~clk;

  logic [9:0] m_x, m_y, f_x, f_y, s_x, s_y, t_x, t_y;
  logic       m_pe, m_ft, m_hs, m_vs, m_vo;
  logic       f_pe, f_ft, f_hs, f_vs, f_vo;
  logic       s_pe, s_ft, s_hs, s_vs, s_vo;
  logic       t_pe, t_ft, t_hs, t_vs, t_vo;
  logic [7:0] m_rgb, f_rgb, s_rgb, t_rgb;

  vga_timing_gen u_main (
    .clk (clk), .rst (rst), .color_in (color),
    .pixel_x (m_x), .pixel_y (m_y), .pix_en (m_pe), .frame_tick (m_ft),
    .hsync (m_hs), .vsync (m_vs), .video_on (m_vo), .rgb_out (m_rgb)
  );

  vga_timing_gen #(.CLK_DIV (1), .PIPE_DLY (0)) u_fast (
    .clk (clk), .rst (rst), .color_in (color),
    .pixel_x (f_x), .pixel_y (f_y), .pix_en (f_pe), .frame_tick (f_ft),
    .hsync (f_hs), .vsync (f_vs), .video_on (f_vo), .rgb_out (f_rgb)
  );

  // H: 8 active, sync [10,13), total 16. V: 4 active, sync [5,7), total 8.
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .CLK_DIV (2), .PIPE_DLY (2)
  ) u_small (
    .clk (clk), .rst (rst), .color_in (color),
    .pixel_x (s_x), .pixel_y (s_y), .pix_en (s_pe), .frame_tick (s_ft),
    .hsync (s_hs), .vsync (s_vs), .video_on (s_vo), .rgb_out (s_rgb)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .CLK_DIV (1), .PIPE_DLY (0)
  ) u_tiny (
    .clk (clk), .rst (rst), .color_in (color),
    .pixel_x (t_x), .pixel_y (t_y), .pix_en (t_pe), .frame_tick (t_ft),
    .hsync (t_hs), .vsync (t_vs), .video_on (t_vo), .rgb_out (t_rgb)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Main-instance monitor state; coordinate histories start outside the active area.
  int   mx1 = 1023, mx2 = 1023, mx3 = 1023;
  int   my1 = 1023, my2 = 1023, my3 = 1023;
  int   bad_m = 0, bad_rgb = 0, bad_hold = 0, bad_edge = 0;
  int   run = 0, max_x = 0, x656_c = -100, hs_falls = 0, hs_rises = 0, hs_low = 0;
  logic prev_hs = 1'b1;
  logic exp_hs, exp_vo;
  logic [7:0] exp_rgb;
  // Fast instance.
  int   bad_f = 0, fx, fy;
  logic f_vo_prev = 1'b0, f_exp_hs, f_exp_vo;
  // Small instance.
  int   bad_s = 0, s_last = 0, s_ticks = 0, s_ff = 0, s_y5 = -100, s_vfalls = 0, s_vlow = 0;
  int   s_max_x = 0, s_max_y = 0, sy1 = 0;
  logic s_vs_prev = 1'b1;
  // Tiny instance.
  int   bad_t = 0, t_last = 0, t_ticks = 0, ty1 = 0;
  bit   found;

  initial begin
    rst   = 1'b1;
    color = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_en", m_pe, 0);
    chk("rst_fast_pix_en", f_pe, 0);
    chk("rst_frame_tick", m_ft, 0);
    chk("rst_pixel_x", m_x, 0);
    chk("rst_pixel_y", m_y, 0);
    chk("rst_hsync", m_hs, 1);
    chk("rst_vsync", m_vs, 1);
    chk("rst_video_on", m_vo, 0);
    chk("rst_rgb", m_rgb, 0);

    @(posedge clk);
    #1 rst = 1'b0;

    // c = 0 is the first clk after release; samples taken on the falling edge.
    for (int c = 0; c <= 4800; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("rel_frame_tick", m_ft, 1);
        chk("rel_pix_en", m_pe, 0);
        chk("rel_fast_pix_en", f_pe, 1);
        chk("rel_small_frame_tick", s_ft, 1);
      end
      if (c == 1) begin
        chk("first_pix_en_c1", m_pe, 1);
        chk("video_on_c1", m_vo, 0);
      end
      if (c == 2) begin
        chk("pixel_x_c2", m_x, 1);
        chk("video_on_c2", m_vo, 1);
        chk("rgb_c2", m_rgb, 8'h00);
      end
      if (c == 3) chk("first_rgb_c3", m_rgb, 8'hFF);

      // Main: terms lag coordinates by 2 clks, rgb by 3.
      exp_hs  = !(mx2 >= 656 && mx2 < 752);
      exp_vo  = (mx2 < 640) && (my2 < 480);
      exp_rgb = ((mx3 < 640) && (my3 < 480)) ? 8'hFF : 8'h00;
      if (m_hs !== exp_hs || m_vs !== 1'b1 || m_vo !== exp_vo) bad_m++;
      if (m_rgb !== exp_rgb) bad_rgb++;
      if (m_pe !== logic'(c % 2 == 1)) bad_m++;
      if (c > 0 && m_ft !== 1'b0) bad_m++;
      if (c == 0) run = 1;
      else if (int'(m_x) != mx1) begin
        if (run != 2) bad_hold++;
        run = 1;
      end else run++;
      if (int'(m_x) > max_x) max_x = int'(m_x);
      if (m_x == 10'd656 && mx1 != 656) x656_c = c;
      if (!m_hs && prev_hs) begin
        hs_falls++;
        if (c - x656_c != 2) bad_edge++;
      end
      if (m_hs && !prev_hs) begin
        hs_rises++;
        if (hs_low != 192) bad_edge++;
        hs_low = 0;
      end
      if (!m_hs) hs_low++;
      mx3 = mx2; mx2 = mx1; mx1 = int'(m_x);
      my3 = my2; my2 = my1; my1 = int'(m_y);
      prev_hs = m_hs;

      // Fast: counters step every clk, terms same clk, rgb one clk later.
      fx = c % 800;
      fy = c / 800;
      f_exp_hs = !(fx >= 656 && fx < 752);
      f_exp_vo = (fx < 640) && (fy < 480);
      if (int'(f_x) != fx || int'(f_y) != fy || f_pe !== 1'b1) bad_f++;
      if (f_hs !== f_exp_hs || f_vs !== 1'b1 || f_vo !== f_exp_vo) bad_f++;
      if (f_rgb !== (f_vo_prev ? 8'hFF : 8'h00)) bad_f++;
      if (f_ft !== logic'(c == 0)) bad_f++;
      if (fx == 656 && fy == 0) chk("fast_hsync_at_656", f_hs, 0);
      f_vo_prev = f_exp_vo;

      // Small: 256-clk frames, 64 lit clks each, vsync 64 clks starting 2 clks after y=5.
      if (s_ft) begin
        if (c > 0) begin
          s_ticks++;
          if (c - s_last != 256) bad_s++;
          if (s_ff != 64) bad_s++;
        end
        s_last = c;
        s_ff   = 0;
      end
      if (s_rgb == 8'hFF) s_ff++;
      if (s_y == 10'd5 && sy1 != 5) begin
        s_y5 = c;
        if (s_x != 10'd0) bad_s++;
      end
      if (!s_vs && s_vs_prev) begin
        s_vfalls++;
        if (c - s_y5 != 2) bad_s++;
      end
      if (s_vs && !s_vs_prev) begin
        if (s_vlow != 64) bad_s++;
        s_vlow = 0;
      end
      if (!s_vs) s_vlow++;
      if (int'(s_x) > s_max_x) s_max_x = int'(s_x);
      if (int'(s_y) > s_max_y) s_max_y = int'(s_y);
      sy1 = int'(s_y);
      s_vs_prev = s_vs;

      // Tiny: 128-clk frames, vsync in the same clk y becomes 5.
      if (t_ft) begin
        if (c > 0) begin
          t_ticks++;
          if (c - t_last != 128) bad_t++;
        end
        t_last = c;
      end
      if (t_y == 10'd5 && ty1 != 5 && t_vs !== 1'b0) bad_t++;
      if (t_pe !== 1'b1) bad_t++;
      ty1 = int'(t_y);
    end

    chk("main_timing_terms", bad_m, 0);
    chk("main_rgb_gating", bad_rgb, 0);
    chk("main_pixel_hold", bad_hold, 0);
    chk("main_hsync_edges", bad_edge, 0);
    chk("main_hsync_falls", hs_falls, 3);
    chk("main_hsync_rises", hs_rises, 3);
    chk("main_max_x", max_x, 799);
    chk("main_x_after_3_lines", m_x, 0);
    chk("main_y_after_3_lines", m_y, 3);
    chk("fast_checks", bad_f, 0);
    chk("small_checks", bad_s, 0);
    chk("small_ticks", s_ticks, 18);
    chk("small_vsync_falls", s_vfalls, 19);
    chk("small_max_x", s_max_x, 15);
    chk("small_max_y", s_max_y, 7);
    chk("tiny_checks", bad_t, 0);
    chk("tiny_ticks", t_ticks, 37);

    // Mid-frame reset at (300,3).
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (m_x == 10'd300) found = 1'b1;
    end
    chk("seek_x300", found, 1);
    chk("pre_rst_rgb", m_rgb, 8'hFF);
    chk("pre_rst_y", m_y, 3);
    rst   = 1'b1;
    color = 8'hE0;
    #1;
    chk("rstcyc_pix_en", m_pe, 0);
    chk("rstcyc_frame_tick", m_ft, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_x", m_x, 0);
    chk("mid_rst_y", m_y, 0);
    chk("mid_rst_hsync", m_hs, 1);
    chk("mid_rst_vsync", m_vs, 1);
    chk("mid_rst_rgb", m_rgb, 0);
    chk("mid_rst_video_on", m_vo, 0);
    chk("mid_rst_frame_tick", m_ft, 1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rgb_c2", m_rgb, 8'h00);
    @(negedge clk);
    chk("mid_rgb_red_c3", m_rgb, 8'hE0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
